// File: rtl/sqrt_share_pkg.sv
// Shared types and default sizing for the square-root sharing controller.
package sqrt_share_pkg;

  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_WIDTH   = 24;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requester at or above ptr, else lowest overall.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] pick_from;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      mask[i] = (i >= 32'(ptr));
    end
    masked    = req & mask;
    pick_from = (masked != '0) ? masked : req;
    grant     = '0;
    idx       = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int unsigned i = NREQ; i > 0; i--) begin
      if (pick_from[i-1]) begin
        grant      = '0;
        grant[i-1] = 1'b1;
        idx        = IW'(i - 1);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/sqrt_share_ctrl.sv
// Round-robin sharing of one iterative square-root unit between NREQ requesters,
// with a watchdog that turns a hung unit into an error response.
module sqrt_share_ctrl
  import sqrt_share_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_n_i,
  output logic [NREQ-1:0]       rsp_valid_o,
  input  logic [NREQ-1:0]       rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_q_o,
  output logic [WIDTH-1:0]      rsp_r_o,
  output logic                  rsp_err_o,
  output logic                  sq_start_o,
  output logic [WIDTH-1:0]      sq_n_o,
  input  logic [WIDTH-1:0]      sq_q_i,
  input  logic [WIDTH-1:0]      sq_r_i,
  input  logic                  sq_valid_i,
  output logic                  busy_o
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WD_LAST  = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_REQ = IW'(NREQ - 1);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt_oh;
  logic [CW-1:0]   wd_cnt;

  logic [NREQ-1:0]  arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic [WIDTH-1:0] req_n [NREQ];

  for (genvar k = 0; k < int'(NREQ); k++) begin : g_unpack
    assign req_n[k] = req_n_i[k*WIDTH +: WIDTH];
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid_i),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    req_ready_o = (state == IDLE) ? arb_grant : '0;
    rsp_valid_o = (state == RESP) ? gnt_oh : '0;
    sq_start_o  = (state == ISSUE);
    busy_o      = (state != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      gnt_oh    <= '0;
      wd_cnt    <= '0;
      sq_n_o    <= '0;
      rsp_q_o   <= '0;
      rsp_r_o   <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            sq_n_o  <= req_n[arb_idx];
            gnt_idx <= arb_idx;
            gnt_oh  <= arb_grant;
            ptr     <= (arb_idx == LAST_REQ) ? '0 : arb_idx + 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          // A result arriving on the expiry cycle still takes priority over the abort.
          if (sq_valid_i) begin
            rsp_q_o   <= sq_q_i;
            rsp_r_o   <= sq_r_i;
            rsp_err_o <= 1'b0;
            state     <= RESP;
          end else if (wd_cnt == WD_LAST) begin
            rsp_q_o   <= '0;
            rsp_r_o   <= '0;
            rsp_err_o <= 1'b1;
            state     <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i[gnt_idx]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// Scoreboard bench for sqrt_share_ctrl with a behavioural square-root unit and randomized traffic.
module tb_sqrt_share_ctrl;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned W       = 24;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned LAT     = W/2 + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_i;
  logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [W-1:0]        req_n [NREQ];
  logic [NREQ*W-1:0]   req_n_flat;
  logic [W-1:0]        rsp_q, rsp_r, sq_n;
  logic [W-1:0]        sq_q = '0;
  logic [W-1:0]        sq_r = '0;
  logic                sq_valid = 1'b0;
  logic                rsp_err, sq_start, busy;

  always_comb begin
    req_n_flat = '0;
    for (int k = 0; k < int'(NREQ); k++) req_n_flat[k*W +: W] = req_n[k];
  end

  sqrt_share_ctrl #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_n_i(req_n_flat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_q_o(rsp_q), .rsp_r_o(rsp_r), .rsp_err_o(rsp_err),
    .sq_start_o(sq_start), .sq_n_o(sq_n), .sq_q_i(sq_q), .sq_r_i(sq_r),
    .sq_valid_i(sq_valid), .busy_o(busy)
  );

  typedef struct {
    int unsigned req;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
  } exp_t;

  exp_t        sb[$];
  int unsigned grant_log[$];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic longint unsigned isqrt(input longint unsigned n);
    longint unsigned lo = 0;
    longint unsigned hi = (64'd1 << (W/2)) - 1;
    longint unsigned mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= n) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic int unsigned first_one(input logic [NREQ-1:0] v);
    for (int unsigned i = 0; i < NREQ; i++) if (v[i]) return i;
    return NREQ;
  endfunction

  // Behavioural sqrt unit: fixed latency, optional hang, optional stray strobe.
  bit              hang = 1'b0;
  int unsigned     late_cnt = 0;
  int unsigned     late_seen = 0;
  int unsigned     cd = 0;
  logic [W-1:0]    hold_n = '0;

  always @(posedge clk) begin
    #1;
    sq_valid = 1'b0;
    if (!busy) cd = 0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        check("sq_n_stable", sq_n, hold_n);
        sq_q     = W'(isqrt(hold_n));
        sq_r     = W'(hold_n - isqrt(hold_n) * isqrt(hold_n));
        sq_valid = 1'b1;
      end
    end
    if (sq_start) begin
      hold_n = sq_n;
      if (!hang) cd = LAT;
    end
    if (late_cnt != late_seen) begin
      late_seen = late_cnt;
      sq_q      = W'($urandom | 32'd1);
      sq_r      = W'($urandom);
      sq_valid  = 1'b1;
    end
  end

  // Monitor: arbitration model, scoreboard push on accept, pop/compare on response.
  int unsigned     mptr = 0;
  bit              exp_start = 1'b0;
  bit              prev_hold = 1'b0;
  logic [NREQ-1:0] prev_v, m_acc;
  logic [W-1:0]    prev_q, prev_r;
  logic            prev_err;
  int unsigned     m_g, m_eg, m_k;
  exp_t            m_e;
  int unsigned     last_req = 0;
  logic [W-1:0]    last_q = '0;
  logic [W-1:0]    last_r = '0;
  logic            last_err = 1'b0;
  int unsigned     n_rsp = 0;

  always @(negedge clk) begin
    if (reset_i) begin
      sb.delete();
      mptr      = 0;
      prev_hold = 1'b0;
      exp_start = 1'b0;
    end else begin
      if (exp_start) begin
        check("start_latency", sq_start, 1);
        exp_start = 1'b0;
      end
      if (busy) check("ready_while_busy", req_ready, 0);
      m_acc = req_valid & req_ready;
      if (m_acc != '0) begin
        check("ready_onehot", $countones(m_acc), 1);
        m_eg = NREQ;
        for (int unsigned i = 0; i < NREQ; i++) begin
          m_k = (mptr + i) % NREQ;
          if (m_eg == NREQ && req_valid[m_k]) m_eg = m_k;
        end
        m_g = first_one(m_acc);
        check("rr_grant", m_g, m_eg);
        check("one_in_flight", sb.size(), 0);
        m_e.req = m_eg;
        if (hang) begin
          m_e.q = '0; m_e.r = '0; m_e.err = 1'b1;
        end else begin
          m_e.q   = W'(isqrt(req_n[m_eg]));
          m_e.r   = W'(req_n[m_eg] - isqrt(req_n[m_eg]) * isqrt(req_n[m_eg]));
          m_e.err = 1'b0;
        end
        sb.push_back(m_e);
        grant_log.push_back(m_g);
        mptr      = (m_eg + 1) % NREQ;
        exp_start = 1'b1;
      end
      if (rsp_valid != '0) begin
        if (prev_hold) begin
          check("hold_valid", rsp_valid, prev_v);
          check("hold_q", rsp_q, prev_q);
          check("hold_r", rsp_r, prev_r);
          check("hold_err", rsp_err, prev_err);
        end
        if (sb.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 0);
        end else begin
          check("rsp_owner", rsp_valid, 64'd1 << sb[0].req);
          check("rsp_q", rsp_q, sb[0].q);
          check("rsp_r", rsp_r, sb[0].r);
          check("rsp_err", rsp_err, sb[0].err);
        end
        if ((rsp_valid & rsp_ready) != '0) begin
          if (sb.size() > 0) begin
            last_req = first_one(rsp_valid);
            last_q   = rsp_q;
            last_r   = rsp_r;
            last_err = rsp_err;
            void'(sb.pop_front());
            n_rsp++;
          end
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          prev_v    = rsp_valid;
          prev_q    = rsp_q;
          prev_r    = rsp_r;
          prev_err  = rsp_err;
        end
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int unsigned max);
    logic [NREQ-1:0] acc;
    bit done = 1'b0;
    for (int unsigned i = 0; i < max && !done; i++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (req_valid == '0 && !busy && sb.size() == 0) done = 1'b1;
      else begin
        tick();
        req_valid = req_valid & ~acc;
      end
    end
    check(name, done, 1);
  endtask

  task automatic wait_start(output bit seen);
    logic [NREQ-1:0] acc;
    seen = 1'b0;
    for (int unsigned i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (sq_start) seen = 1'b1;
      else begin
        acc = req_valid & req_ready;
        tick();
        req_valid = req_valid & ~acc;
      end
    end
  endtask

  function automatic logic [W-1:0] rand_n();
    int unsigned pick = $urandom_range(9);
    if (pick == 0) return '0;
    if (pick == 1) return '1;
    return W'($urandom);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual=stuck required=finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    int unsigned k, base, issued;
    logic [NREQ-1:0] acc;
    int unsigned exp_gr [4] = '{0, 2, 0, 2};

    reset_i   = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    for (int i = 0; i < int'(NREQ); i++) req_n[i] = '0;
    repeat (3) tick();
    reset_i = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_sq_start", sq_start, 0);
    check("rst_sq_n", sq_n, 0);
    check("rst_q", rsp_q, 0);
    check("rst_r", rsp_r, 0);
    check("rst_err", rsp_err, 0);

    // Test 1: n=16 on requester 0.
    tick();
    req_n[0] = 24'd16; req_valid = 4'b0001; rsp_ready = '1;
    wait_done("t1_done", 200);
    check("t1_req", last_req, 0);
    check("t1_q", last_q, 4);
    check("t1_r", last_r, 0);
    check("t1_err", last_err, 0);

    // Test 2: n=1000 on requester 1.
    tick();
    req_n[1] = 24'd1000; req_valid = 4'b0010;
    wait_done("t2_done", 200);
    check("t2_req", last_req, 1);
    check("t2_q", last_q, 31);
    check("t2_r", last_r, 39);

    // Test 3: requesters 0 and 2 held high from ptr=0.
    tick(); reset_i = 1'b1; tick(); tick(); reset_i = 1'b0;
    grant_log.delete();
    req_n[0] = rand_n(); req_n[2] = rand_n(); req_valid = 4'b0101;
    for (int unsigned i = 0; i < 400 && grant_log.size() < 4; i++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      tick();
      for (int unsigned j = 0; j < NREQ; j++) if (acc[j]) req_n[j] = rand_n();
    end
    req_valid = '0;
    wait_done("t3_done", 200);
    check("t3_grants", grant_log.size(), 4);
    for (int unsigned i = 0; i < 4 && i < grant_log.size(); i++)
      check("t3_order", grant_log[i], exp_gr[i]);

    // Test 4: response stall with another request pending.
    tick();
    req_n[1] = rand_n(); req_n[3] = rand_n(); req_valid = 4'b1010; rsp_ready = '0;
    seen = 1'b0;
    for (int unsigned i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) seen = 1'b1;
      else begin
        acc = req_valid & req_ready;
        tick();
        req_valid = req_valid & ~acc;
      end
    end
    check("t4_rsp_seen", seen, 1);
    repeat (5) tick();
    rsp_ready = '1;
    wait_done("t4_done", 300);

    // Test 5: hung unit, watchdog abort, then stray strobes in RESP and IDLE.
    tick();
    hang = 1'b1; req_n[2] = rand_n(); req_valid = 4'b0100; rsp_ready = '0;
    wait_start(seen);
    check("t5_start_seen", seen, 1);
    k = 0; seen = 1'b0;
    for (int unsigned i = 0; i < TIMEOUT + 20 && !seen; i++) begin
      @(negedge clk);
      k++;
      if (rsp_valid != '0) seen = 1'b1;
    end
    // Abort decided TIMEOUT edges after the start edge, visible one cycle later.
    check("t5_abort_cycles", k, TIMEOUT + 1);
    tick();
    late_cnt++;
    repeat (4) tick();
    rsp_ready = '1;
    wait_done("t5_done", 100);
    check("t5_err", last_err, 1);
    check("t5_q", last_q, 0);
    check("t5_r", last_r, 0);
    hang = 1'b0;
    tick();
    late_cnt++;
    repeat (3) begin
      @(negedge clk);
      check("late_idle_busy", busy, 0);
      check("late_idle_rsp", rsp_valid, 0);
    end

    // Test 6: reset while waiting on the unit.
    tick();
    req_n[1] = rand_n(); req_valid = 4'b0010; rsp_ready = '1;
    wait_start(seen);
    check("t6_start_seen", seen, 1);
    repeat (3) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_req_ready", req_ready, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_sq_start", sq_start, 0);
    check("t6_sq_n", sq_n, 0);
    check("t6_q", rsp_q, 0);
    check("t6_r", rsp_r, 0);
    check("t6_err", rsp_err, 0);
    repeat (25) tick();
    base = n_rsp;
    req_n[1] = rand_n(); req_valid = 4'b0010;
    wait_done("t6_done", 200);
    check("t6_rsp_count", n_rsp - base, 1);
    check("t6_req", last_req, 1);

    // Random traffic with random response back-pressure.
    base = n_rsp; issued = 0; seen = 1'b0;
    for (int unsigned c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (issued == 40 && req_valid == '0 && !busy && sb.size() == 0) seen = 1'b1;
      else begin
        tick();
        req_valid = req_valid & ~acc;
        rsp_ready = NREQ'($urandom);
        for (int unsigned j = 0; j < NREQ; j++) begin
          if (!req_valid[j] && issued < 40 && $urandom_range(3) == 0) begin
            req_n[j] = rand_n();
            req_valid[j] = 1'b1;
            issued++;
          end
        end
      end
    end
    check("rand_done", seen, 1);
    check("rand_rsp_count", n_rsp - base, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
